pe_loader: RTL
==============

Name: pe_loader

Overview:
- Writer side of the PE local-memory read interface. pe_controller issues rdaddr and consumes rddata one cycle later. pe_loader fills that same memory.
- Accepts a 32-bit word stream over a valid/ready handshake and writes it to consecutive addresses 0..2^(L_RAM_SIZE+1)-1 (vector A then vector B).
- When the buffer is full, it pulses pe_start so pe_controller can begin.

Parameters:
- VECTOR_SIZE, 16, entries per vector; must equal 2**L_RAM_SIZE.
- L_RAM_SIZE, 4, log2 of vector size; memory depth DEPTH = 2**(L_RAM_SIZE+1) words.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load.
- abort  in  1  one-cycle pulse; cancels a load in progress.
- s_data  in  32  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a word.
- wraddr  out  L_RAM_SIZE+1  memory write address.
- wrdata  out  32  memory write data.
- wren  out  1  memory write strobe.
- done  out  1  buffer full; sticky.
- pe_start  out  1  one-cycle pulse to pe_controller start.

Behaviour:
- Reset: synchronous, active-high. One clock domain (aclk). While areset=1:
  - state=IDLE, count=0.
  - s_ready=0, wren=0, wraddr=0, wrdata=0, done=0, pe_start=0.
- Reset during LOAD discards the partial load. No write is issued in the reset cycle or the cycle after.
- States:
  - IDLE: s_ready=0. start -> LOAD with count=0.
  - LOAD: s_ready=1, decoded from state, not registered. A handshake (s_valid & s_ready) accepts s_data and increments count.
    - Handshake with count==DEPTH-1 -> DONE; s_ready is 0 from the next cycle.
    - abort -> IDLE with count=0. No write is issued for a word presented in the abort cycle; abort takes priority over the handshake.
    - start in LOAD is ignored.
  - DONE: done=1 and s_ready=0.
    - start -> LOAD, count=0; done clears the cycle after start is sampled.
    - abort in DONE -> IDLE, done=0.
- Write port, registered with 1-cycle latency:
  - A handshake in cycle N gives wren=1, wraddr=count(N), wrdata=s_data(N) in cycle N+1.
  - wren=0 in any cycle not following a handshake.
  - Back-to-back handshakes give continuous wren with wraddr incrementing by 1.
- pe_start: high for exactly one cycle, the cycle after the last write strobe (wren with wraddr=DEPTH-1). The memory therefore holds all DEPTH words before pe_controller issues its first rdaddr.
- done: rises in the same cycle as pe_start and holds until start, abort or reset.
- count is L_RAM_SIZE+2 bits wide internally, so DEPTH is representable. wraddr is its low L_RAM_SIZE+1 bits and never wraps within a load.
- s_valid with s_ready=0 (IDLE or DONE) is ignored. The word is not consumed and no write occurs.
- start and abort in the same cycle: abort wins.

Optional Feature:
- Macro: PE_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (32 bits): wrapping 32-bit sum of all words accepted in the current load.
  - Cleared on reset, on start and on abort.
  - Updated one cycle after each handshake, aligned with wren.
  - Final value is valid when done=1.
- Undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Shared package pe_pkg holds:
  - DATA_W=32.
  - State encoding IDLE/LOAD/DONE (2-bit typedef).
  - A depth constant/function DEPTH(L)=2**(L+1).
  - The same package is used by pe_controller.
- One natural sub-module: pe_loader_cnt.
  - Address counter with clear, enable and last flag (count==DEPTH-1).
  - Instantiated once.

Test Plan:
- Reset then idle: areset high 5 cycles, s_valid=1 with s_data=32'hDEAD_BEEF -> s_ready=0, wren never asserted, done=0.
- Full load, no stalls: start pulse, then 32 consecutive words 32'h0000_0000..32'h0000_001F with s_valid=1:
  - wren high 32 consecutive cycles, wraddr 0..31, wrdata==wraddr.
  - pe_start single pulse the cycle after wraddr=31.
  - done=1 thereafter.
- Gapped valid: s_valid toggles 1/0 per cycle -> exactly 32 writes, addresses contiguous, no write in gap+1 cycles, pe_start after the 32nd write.
- Abort mid-load: abort after 10 words -> state IDLE, no 11th write, done=0. A fresh start then writes from wraddr=0.
- Reload from DONE and start+abort collision:
  - start in DONE -> done clears the cycle after start is sampled, new load begins at 0.
  - start and abort in the same cycle -> IDLE.
- Checksum (PE_LOADER_CHECKSUM_EN): words 1..32 -> checksum=528 (32'h210) when done=1. Words all 32'hFFFF_FFFF -> checksum=32'hFFFF_FFE0 (wrap).

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the PE loader and controller
package pe_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  function automatic int depth(input int l);
    return 2 ** (l + 1);
  endfunction
endpackage

// File: rtl/pe_loader_cnt.sv
// pe_loader_cnt: load address counter with clear, enable and last flag; ports clk, rst, clr_i, en_i -> count_o (address bits), last_o (count==LAST)
module pe_loader_cnt #(
  parameter int CW = 6,
  parameter int AW = 5,
  parameter int LAST = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] count_o,
  output logic          last_o
);
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (rst || clr_i) count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  assign count_o = count_q[AW-1:0];
  assign last_o = count_q == CW'(LAST);
endmodule

// File: rtl/pe_loader.sv
// pe_loader: streams DEPTH words into PE local memory then pulses pe_start; ports aclk/areset, start/abort, s_data/s_valid/s_ready, wraddr/wrdata/wren, done, pe_start, and checksum when PE_LOADER_CHECKSUM_EN is defined
module pe_loader
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = 16,
  parameter int L_RAM_SIZE = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [L_RAM_SIZE:0]   wraddr,
  output logic [DATA_W-1:0]     wrdata,
  output logic                  wren,
  output logic                  done,
  output logic                  pe_start
`ifdef PE_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);
  localparam int AW = L_RAM_SIZE + 1;
  localparam int LAST = depth(L_RAM_SIZE) - 1;
  if (VECTOR_SIZE != 2 ** L_RAM_SIZE) begin : g_bad_size
    $error("VECTOR_SIZE must equal 2**L_RAM_SIZE");
  end
  state_t state_q, state_d;
  logic hs, clr, last, wren_q, done_q, pe_start_q;
  logic [AW-1:0] count, wraddr_q;
  logic [DATA_W-1:0] wrdata_q;
  // start is ignored mid-load, so only a start outside LOAD restarts the count
  assign clr = abort || (start && state_q != LOAD);
  pe_loader_cnt #(.CW(L_RAM_SIZE + 2), .AW(AW), .LAST(LAST)) u_cnt (
    .clk(aclk), .rst(areset), .clr_i(clr), .en_i(hs), .count_o(count), .last_o(last)
  );
  always_ff @(posedge aclk)
    if (areset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = abort ? IDLE :
              state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? ((hs && last) ? DONE : LOAD) :
              state_q == DONE ? (start ? LOAD : DONE) : IDLE;
  always_comb begin
    s_ready = state_q == LOAD && !areset;
    hs = s_ready && s_valid && !abort;
  end
  always_ff @(posedge aclk)
    if (areset) begin
      wren_q <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      pe_start_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wren_q <= hs;
      if (hs) wraddr_q <= count;
      if (hs) wrdata_q <= s_data;
      pe_start_q <= wren_q && wraddr_q == AW'(LAST);
      done_q <= clr ? 1'b0 : (wren_q && wraddr_q == AW'(LAST)) ? 1'b1 : done_q;
    end
  assign wren = wren_q;
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;
  assign pe_start = pe_start_q;
  assign done = done_q;
`ifdef PE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  always_ff @(posedge aclk)
    if (areset || clr) sum_q <= '0;
    else if (hs) sum_q <= sum_q + s_data;
  assign checksum = sum_q;
`endif
endmodule
